// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage, instruction ROM, decode and branch unit.
package cpu_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] instr_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Whole word aligned and entirely inside the ROM.
  function automatic logic addr_in_bounds(input addr_t a, input int unsigned imem_bytes);
    addr_t last_word;
    last_word = addr_t'(imem_bytes - INSTR_BYTES);
    return (a[1:0] == 2'b00) && (a <= last_word);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC select and ROM bounds checks.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 32,
  parameter addr_t       RESET_PC   = 64'd0
) (
  input  logic  clk,
  input  logic  reset_i,
  input  logic  redirect_valid_i,
  input  addr_t redirect_pc_i,
  input  logic  pc_inc_i,
  output addr_t pc_o,
  output logic  pc_ok_o,
  output logic  redirect_ok_o
);

  addr_t pc_q;
  addr_t pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (pc_inc_i) begin
      pc_d = pc_q + addr_t'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_ok_o       = addr_in_bounds(pc_q, IMEM_BYTES);
  assign redirect_ok_o = addr_in_bounds(redirect_pc_i, IMEM_BYTES);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: RUN/HALT control and the IF/ID output register
// in front of decode; the PC itself lives in fetch_pc_reg.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 32,
  parameter addr_t       RESET_PC   = 64'd0
) (
  input  logic         clk,
  input  logic         reset,
  output logic [63:0]  imem_addr,
  input  logic [31:0]  imem_instr,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_instr,
  output logic [63:0]  out_pc,
  output logic         halted,
  output logic         misalign_err
);

  fetch_state_t state_q, state_d;
  logic         out_valid_q, out_valid_d;
  instr_t       out_instr_q, out_instr_d;
  addr_t        out_pc_q, out_pc_d;
  logic         misalign_q, misalign_d;
  logic         pc_inc;
  addr_t        pc;
  logic         pc_ok;
  logic         redirect_ok;
  logic         adv;

  fetch_pc_reg #(
    .IMEM_BYTES(IMEM_BYTES),
    .RESET_PC  (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .reset_i         (reset),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .pc_inc_i        (pc_inc),
    .pc_o            (pc),
    .pc_ok_o         (pc_ok),
    .redirect_ok_o   (redirect_ok)
  );

  assign adv = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    misalign_d  = misalign_q;
    pc_inc      = 1'b0;
    if (redirect_valid) begin
      // The word on imem_instr this cycle belongs to the wrong path.
      out_valid_d = 1'b0;
      state_d     = redirect_ok ? RUN : HALT;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (adv) begin
            if (pc_ok) begin
              out_instr_d = imem_instr;
              out_pc_d    = pc;
              out_valid_d = 1'b1;
              pc_inc      = 1'b1;
            end else begin
              out_valid_d = 1'b0;
              state_d     = HALT;
            end
          end
        end
        HALT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        default: state_d = HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_addr    = pc;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign halted       = (state_q == HALT);
  assign misalign_err = misalign_q;

endmodule
